// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state codes, default target address, R/W encoding
// and the address-match helper used by targets on this bus.
package i2c_pkg;

    localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h1A;
    localparam logic       I2C_RW_WRITE     = 1'b0;

    typedef logic [2:0] i2c_state_t;

    localparam i2c_state_t ST_IDLE     = 3'd0;
    localparam i2c_state_t ST_ADDR     = 3'd1;
    localparam i2c_state_t ST_ACK_ADDR = 3'd2;
    localparam i2c_state_t ST_DATA     = 3'd3;
    localparam i2c_state_t ST_ACK_DATA = 3'd4;
    localparam i2c_state_t ST_IGNORE   = 3'd5;

    // True when the address byte names this target with a write request.
    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] own_addr);
        return (addr_byte[7:1] == own_addr) && (addr_byte[0] == I2C_RW_WRITE);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises SCL/SDA into the clk domain and derives SCL edges plus
// START/STOP bus conditions from the synchronised and one-clk-delayed copies.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_chain_r;
    logic [SYNC_STAGES-1:0] sda_chain_r;
    logic                   scl_q_r;
    logic                   sda_q_r;

    // Sync chains and delayed copies; reset to the idle-bus level (high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_chain_r <= {SYNC_STAGES{1'b1}};
            sda_chain_r <= {SYNC_STAGES{1'b1}};
            scl_q_r     <= 1'b1;
            sda_q_r     <= 1'b1;
        end else begin
            scl_chain_r <= {scl_chain_r[SYNC_STAGES-2:0], scl};
            sda_chain_r <= {sda_chain_r[SYNC_STAGES-2:0], sda};
            scl_q_r     <= scl_chain_r[SYNC_STAGES-1];
            sda_q_r     <= sda_chain_r[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_chain_r[SYNC_STAGES-1];
    assign sda_s     = sda_chain_r[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_q_r;
    assign scl_fall  = ~scl_s & scl_q_r;
    // SDA moving while SCL is stable high marks a bus condition.
    assign start_det = scl_s & scl_q_r & sda_q_r & ~sda_s;
    assign stop_det  = scl_s & scl_q_r & ~sda_q_r & sda_s;

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: ACKs its own address with W, delivers each received
// data byte as a one-clk strobe, and NACKs everything else.
module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = I2C_DEFAULT_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_hit,
    output logic       bus_busy
);

    logic       scl_s;
    logic       sda_s;
    logic       scl_rise_s;
    logic       scl_fall_s;
    logic       start_det_s;
    logic       stop_det_s;
    logic [7:0] next_byte_s;

    i2c_state_t state_r;
    logic [3:0] bit_cnt_r;
    logic [7:0] shift_r;
    logic [7:0] rx_data_r;
    logic       rx_valid_r;
    logic       addr_hit_r;
    logic       bus_busy_r;
    logic       sda_oe_r;
    logic       hit_pend_r;
    logic       byte_pend_r;

    i2c_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl       (scl),
        .sda       (sda),
        .scl_s     (scl_s),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise_s),
        .scl_fall  (scl_fall_s),
        .start_det (start_det_s),
        .stop_det  (stop_det_s)
    );

    // Byte as it will stand once the current SCL rise has been shifted in.
    assign next_byte_s = {shift_r[6:0], sda_s};

    // Bus busy flag: set by START (incl. repeated START), cleared by STOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_busy_r <= 1'b0;
        end else if (start_det_s) begin
            bus_busy_r <= 1'b1;
        end else if (stop_det_s) begin
            bus_busy_r <= 1'b0;
        end else begin
            bus_busy_r <= bus_busy_r;
        end
    end

    // Receive FSM, ACK drive and output strobes (strobes lag the decision by one clk).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 4'd0;
            shift_r     <= 8'd0;
            rx_data_r   <= 8'd0;
            rx_valid_r  <= 1'b0;
            addr_hit_r  <= 1'b0;
            sda_oe_r    <= 1'b0;
            hit_pend_r  <= 1'b0;
            byte_pend_r <= 1'b0;
        end else begin
            rx_valid_r  <= byte_pend_r;
            addr_hit_r  <= hit_pend_r;
            hit_pend_r  <= 1'b0;
            byte_pend_r <= 1'b0;
            if (byte_pend_r) begin
                rx_data_r <= shift_r;
            end

            if (stop_det_s) begin
                // STOP wins over everything, including an active ACK drive.
                state_r   <= ST_IDLE;
                sda_oe_r  <= 1'b0;
                bit_cnt_r <= 4'd0;
            end else if (start_det_s) begin
                // START or repeated START: drop any partial byte and re-address.
                state_r   <= ST_ADDR;
                sda_oe_r  <= 1'b0;
                bit_cnt_r <= 4'd0;
            end else begin
                case (state_r)
                    ST_ADDR, ST_DATA: begin
                        if (scl_rise_s) begin
                            shift_r   <= next_byte_s;
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            if (bit_cnt_r == 4'd7) begin
                                if (state_r == ST_DATA) begin
                                    byte_pend_r <= 1'b1;
                                    state_r     <= ST_ACK_DATA;
                                end else if (addr_match(next_byte_s, SLAVE_ADDR)) begin
                                    hit_pend_r <= 1'b1;
                                    state_r    <= ST_ACK_ADDR;
                                end else begin
                                    state_r <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_ACK_ADDR, ST_ACK_DATA: begin
                        // First fall starts the ACK bit, second fall ends it.
                        if (scl_fall_s && !scl_s) begin
                            if (!sda_oe_r) begin
                                sda_oe_r <= 1'b1;
                            end else begin
                                sda_oe_r  <= 1'b0;
                                bit_cnt_r <= 4'd0;
                                state_r   <= ST_DATA;
                            end
                        end
                    end
                    ST_IDLE, ST_IGNORE: begin
                        sda_oe_r <= 1'b0;
                    end
                    default: begin
                        state_r  <= ST_IDLE;
                        sda_oe_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda      = sda_oe_r ? 1'b0 : 1'bz;
    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;
    assign addr_hit = addr_hit_r;
    assign bus_busy = bus_busy_r;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Scoreboard bench for i2c_slave_rx: a bit-banged I2C master issues directed and
// random write/read transactions; expected bytes and address hits are queued by
// the stimulus and popped by an independent monitor on the DUT strobes.
module tb_i2c_slave_rx;

    localparam logic [6:0] OWN_ADDR = 7'h1A;
    localparam time        Q        = 50ns;   // quarter SCL period (5 clk)

    logic       clk;
    logic       rst_n;
    logic       scl;
    logic       m_sda_low;
    wire        sda;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_hit;
    logic       bus_busy;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_rx_q[$];
    logic [6:0] exp_hit_q[$];
    logic [7:0] last_rx;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    i2c_slave_rx #(
        .SLAVE_ADDR  (OWN_ADDR),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl      (scl),
        .sda      (sda),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .addr_hit (addr_hit),
        .bus_busy (bus_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Monitor: every strobe must match the head of its expectation queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                n_checks++;
                if (exp_rx_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rx_unexpected: got rx_valid with rx_data=%02h, required no strobe", rx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_rx_q.pop_front();
                    if (rx_data !== e) begin
                        n_fail++;
                        $display("FAIL rx_data: got %02h, required %02h", rx_data, e);
                    end
                end
            end
            if (addr_hit) begin
                n_checks++;
                if (exp_hit_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL addr_hit_unexpected: got addr_hit=1, required 0");
                end else begin
                    void'(exp_hit_q.pop_front());
                end
            end
        end
    end

    // Master bus primitives (SCL low on exit of every task except stop).
    task automatic start_cond();
        m_sda_low = 1'b0; #Q;
        scl = 1'b1;       #Q;
        m_sda_low = 1'b1; #Q;
        scl = 1'b0;       #Q;
        chk("bus_busy_after_start", {31'd0, bus_busy}, 32'd1);
    endtask

    task automatic stop_cond();
        m_sda_low = 1'b1; #Q;
        scl = 1'b1;       #Q;
        m_sda_low = 1'b0; #Q;
        #Q;
        chk("bus_busy_after_stop", {31'd0, bus_busy}, 32'd0);
    endtask

    task automatic send_bit(input logic b);
        m_sda_low = ~b; #Q;
        scl = 1'b1;     #Q;
        if (b) chk("sda_released_in_data_bit", {31'd0, sda}, 32'd1);
        #Q;
        scl = 1'b0;     #Q;
    endtask

    task automatic ack_slot(input logic exp_ack, input string nm);
        m_sda_low = 1'b0; #Q;
        scl = 1'b1;       #Q;
        chk(nm, {31'd0, (sda === 1'b0)}, {31'd0, exp_ack});
        #Q;
        scl = 1'b0;       #Q;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic exp_ack, input string nm);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        ack_slot(exp_ack, nm);
    endtask

    // Reference model of one transaction: the target accepts only its own
    // address with W; accepted bytes are ACKed and delivered in order.
    task automatic transfer(input logic [6:0] addr, input logic rw, input int n,
                            input logic [31:0] data, input logic do_start);
        logic hit;
        hit = (addr == OWN_ADDR) && (rw == 1'b0);
        if (do_start) start_cond();
        if (hit) exp_hit_q.push_back(addr);
        send_byte({addr, rw}, hit, "addr_ack");
        for (int k = 0; k < n; k++) begin
            logic [7:0] d;
            d = data[31-8*k -: 8];
            if (hit) begin
                exp_rx_q.push_back(d);
                last_rx = d;
            end
            send_byte(d, hit, "data_ack");
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        scl       = 1'b1;
        m_sda_low = 1'b0;
        last_rx   = 8'h00;
        #23;
        chk("reset_rx_data",  {24'd0, rx_data}, 32'd0);
        chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_addr_hit", {31'd0, addr_hit}, 32'd0);
        chk("reset_bus_busy", {31'd0, bus_busy}, 32'd0);
        chk("reset_sda_released", {31'd0, sda}, 32'd1);
        rst_n = 1'b1;
        #Q;

        // Own address + W, one byte.
        transfer(OWN_ADDR, 1'b0, 1, 32'hA5000000, 1'b1);
        stop_cond();
        // Foreign address: nothing accepted, rx_data untouched.
        transfer(7'h2B, 1'b0, 1, 32'hFF000000, 1'b1);
        stop_cond();
        chk("rx_data_held", {24'd0, rx_data}, {24'd0, last_rx});
        // Own address + R: NACK, then ignored bytes.
        transfer(OWN_ADDR, 1'b1, 2, 32'h12340000, 1'b1);
        stop_cond();
        chk("rx_data_held_read", {24'd0, rx_data}, {24'd0, last_rx});
        // Back-to-back bytes.
        transfer(OWN_ADDR, 1'b0, 3, 32'h3CC30000, 1'b1);
        stop_cond();

        // Partial byte abandoned by a repeated START.
        start_cond();
        exp_hit_q.push_back(OWN_ADDR);
        send_byte({OWN_ADDR, 1'b0}, 1'b1, "addr_ack");
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        transfer(OWN_ADDR, 1'b0, 1, 32'h5A000000, 1'b1);
        stop_cond();
        chk("rx_data_after_rstart", {24'd0, rx_data}, 32'h5A);

        // Reset asserted while the target drives the address ACK.
        start_cond();
        exp_hit_q.push_back(OWN_ADDR);
        for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : OWN_ADDR[i-1]);
        m_sda_low = 1'b0; #Q;
        scl = 1'b1;       #Q;
        chk("ack_before_reset", {31'd0, (sda === 1'b0)}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("sda_released_on_reset", {31'd0, sda}, 32'd1);
        chk("rx_data_on_reset", {24'd0, rx_data}, 32'd0);
        chk("bus_busy_on_reset", {31'd0, bus_busy}, 32'd0);
        chk("rx_valid_on_reset", {31'd0, rx_valid}, 32'd0);
        chk("addr_hit_on_reset", {31'd0, addr_hit}, 32'd0);
        last_rx = 8'h00;
        #Q;
        rst_n = 1'b1;
        scl = 1'b0; #Q;
        stop_cond();
        transfer(OWN_ADDR, 1'b0, 1, 32'h81000000, 1'b1);
        stop_cond();
        chk("rx_data_after_reset", {24'd0, rx_data}, 32'h81);

        // Randomised transactions.
        for (int t = 0; t < 24; t++) begin
            logic [6:0] a;
            logic       rw;
            a  = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 127)) : OWN_ADDR;
            rw = ($urandom_range(0, 3) == 0);
            transfer(a, rw, $urandom_range(0, 4), $urandom, 1'b1);
            stop_cond();
            chk("rx_data_random", {24'd0, rx_data}, {24'd0, last_rx});
        end

        #200ns;
        chk("rx_queue_drained",  exp_rx_q.size(), 32'd0);
        chk("hit_queue_drained", exp_hit_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
